// File: rtl/scdmem_arbiter_pkg.sv
// Shared types and defaults for the data-RAM arbiter.
// Owner encoding and contention limits.
package scdmem_arbiter_pkg;

  typedef enum logic {
    CPU_OWN = 1'b0,
    DBG_OWN = 1'b1
  } owner_e;

  localparam int unsigned MAX_WAIT_DEF  = 4;
  localparam int unsigned BURST_LEN_DEF = 8;
  localparam int unsigned CNT_W         = 4;

endpackage

// File: rtl/scdmem_mux.sv
// Owner-select mux for the RAM address, write-data and write-enable.
// Purely combinational; the owner comes from the arbiter FSM.
module scdmem_mux
  import scdmem_arbiter_pkg::*;
(
  input  owner_e      owner,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic        mem_we
);

  always_comb begin
    mem_addr   = cpu_addr;
    mem_datain = cpu_wdata;
    mem_we     = 1'b0;
    unique case (owner)
      CPU_OWN: begin
        mem_addr   = cpu_addr;
        mem_datain = cpu_wdata;
        mem_we     = cpu_req & cpu_we;
      end
      DBG_OWN: begin
        mem_addr   = dbg_addr;
        mem_datain = dbg_wdata;
        mem_we     = dbg_req & dbg_we;
      end
      default: mem_we = 1'b0;
    endcase
  end

endmodule

// File: rtl/scdmem_arbiter.sv
// Data-RAM arbiter: CPU has priority, debug/DMA port gets bounded access.
// Starvation and burst counters cap how long either side is held off.
module scdmem_arbiter
  import scdmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT  = MAX_WAIT_DEF,
  parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic [31:0] dbg_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic        mem_we,
  input  logic [31:0] mem_dataout
);

  localparam logic [CNT_W-1:0] WAIT_MAX   = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] BURST_MAX  = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_LEN - 1);

  owner_e           state, state_nx;
  logic [CNT_W-1:0] wait_cnt, wait_nx;
  logic [CNT_W-1:0] burst_cnt, burst_nx;
  logic             mux_we;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= CPU_OWN;
      wait_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nx;
      wait_cnt  <= wait_nx;
      burst_cnt <= burst_nx;
    end
  end

  // >= keeps the handover reachable after an uncontended burst saturates.
  always_comb begin
    state_nx = state;
    wait_nx  = '0;
    burst_nx = '0;
    unique case (state)
      CPU_OWN: begin
        if (dbg_req) begin
          if (!cpu_req || wait_cnt >= WAIT_LAST)
            state_nx = DBG_OWN;
          else if (wait_cnt == WAIT_MAX)
            wait_nx = wait_cnt;
          else
            wait_nx = wait_cnt + 1'b1;
        end
      end
      DBG_OWN: begin
        if (!dbg_req)
          state_nx = CPU_OWN;
        else if (cpu_req && burst_cnt >= BURST_LAST)
          state_nx = CPU_OWN;
        else if (burst_cnt == BURST_MAX)
          burst_nx = burst_cnt;
        else
          burst_nx = burst_cnt + 1'b1;
      end
      default: state_nx = CPU_OWN;
    endcase
  end

  scdmem_mux u_mux (
    .owner      (state),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .mem_addr   (mem_addr),
    .mem_datain (mem_datain),
    .mem_we     (mux_we)
  );

  assign mem_we    = clrn & mux_we;
  assign dbg_gnt   = (state == DBG_OWN) & dbg_req;
  assign cpu_stall = (state == DBG_OWN) & cpu_req;
  assign cpu_rdata = mem_dataout;
  assign dbg_rdata = mem_dataout;

endmodule

// File: tb/tb_scdmem_arbiter.sv
// Scoreboard bench for scdmem_arbiter with a behavioural 32x32 RAM.
// Directed vectors; read data checked by a negedge monitor.
module tb_scdmem_arbiter;

  logic        clk = 1'b0;
  logic        clrn;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        dbg_gnt;
  logic [31:0] mem_addr, mem_datain, mem_dataout;
  logic        mem_we;

  logic [31:0] ram [32];
  logic [31:0] dbg_q [$];
  logic [31:0] cpu_q [$];
  int n_vec = 0;
  int n_err = 0;

  scdmem_arbiter #(.MAX_WAIT(4), .BURST_LEN(8)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .dbg_req     (dbg_req),
    .dbg_we      (dbg_we),
    .dbg_addr    (dbg_addr),
    .dbg_wdata   (dbg_wdata),
    .dbg_gnt     (dbg_gnt),
    .dbg_rdata   (dbg_rdata),
    .mem_addr    (mem_addr),
    .mem_datain  (mem_datain),
    .mem_we      (mem_we),
    .mem_dataout (mem_dataout)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 32; i++) ram[i] = '0;
  always @(posedge clk) if (mem_we) ram[mem_addr[6:2]] <= mem_datain;
  assign mem_dataout = ram[mem_addr[6:2]];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (clrn) begin
      if (dbg_gnt && !dbg_we) begin
        if (dbg_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL dbg_rd: got %h expected none", dbg_rdata);
        end else check("dbg_rd", dbg_rdata, dbg_q.pop_front());
      end
      if (cpu_req && !cpu_we && !cpu_stall) begin
        if (cpu_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL cpu_rd: got %h expected none", cpu_rdata);
        end else check("cpu_rd", cpu_rdata, cpu_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_store(input logic [31:0] a, input logic [31:0] d);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic cpu_load(input logic [31:0] a, input logic [31:0] ex);
    cpu_q.push_back(ex);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    tick();
    cpu_req = 1'b0;
  endtask

  // Holds one debug beat until granted; ew = refused cycles expected.
  task automatic dbg_xfer(input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] ex,
                          input int ew);
    int w = 0;
    bit got = 1'b0;
    if (!we) dbg_q.push_back(ex);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
    while (!got && w <= 20) begin
      #3;
      if (dbg_gnt) begin
        got = 1'b1;
        check("gnt_stall", 32'(cpu_stall), 32'(cpu_req));
        check("gnt_we", 32'(mem_we), 32'(we));
      end else begin
        check("wait_stall", 32'(cpu_stall), 32'd0);
        w++;
      end
      tick();
    end
    check("grant_wait", 32'(w), 32'(ew));
  endtask

  logic [31:0] words [4];
  int waits [12];

  initial begin
    words = '{32'ha3, 32'h27, 32'h79, 32'h115};
    waits = '{4, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0};

    // reset held with both sides requesting writes
    clrn = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b1;
    dbg_addr = 32'h50; dbg_wdata = 32'hBAD0BAD0;
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 32'h4C; cpu_wdata = 32'h0BAD0BAD;
    for (int i = 0; i < 3; i++) begin
      tick(); #3;
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_gnt", 32'(dbg_gnt), 32'd0);
      check("rst_stall", 32'(cpu_stall), 32'd0);
    end
    tick();
    clrn = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
    #3;
    check("post_rst_gnt", 32'(dbg_gnt), 32'd0);
    check("post_rst_stall", 32'(cpu_stall), 32'd0);
    tick();
    dbg_req = 1'b0;
    tick(); tick();

    // uncontended debug write, then CPU reads it back
    dbg_xfer(1'b1, 32'h50, 32'hDEADBEEF, 32'h0, 1);
    dbg_req = 1'b0;
    tick();
    cpu_load(32'h50, 32'hDEADBEEF);

    // starvation bound: grant at t+4, stalled CPU store dropped
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h60;
    dbg_q.push_back(32'hDEADBEEF);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h50;
    for (int i = 0; i < 5; i++) begin
      cpu_wdata = 32'(i);
      #3;
      check("starve_gnt", 32'(dbg_gnt), 32'(i == 4));
      check("starve_stall", 32'(cpu_stall), 32'(i == 4));
      check("starve_we", 32'(mem_we), 32'(i < 4));
      tick();
    end
    dbg_req = 1'b0; cpu_wdata = 32'd5;
    #3;
    check("drop_stall", 32'(cpu_stall), 32'd1);
    check("drop_we", 32'(mem_we), 32'd0);
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    cpu_load(32'h60, 32'd3);

    for (int i = 0; i < 4; i++)
      cpu_store(32'h50 + 32'(4 * i), words[i]);

    // debug drops after 3 contended beats
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 32'h7C; cpu_wdata = 32'h0;
    for (int i = 0; i < 3; i++)
      dbg_xfer(1'b0, 32'h50 + 32'(4 * i), 32'h0, words[i],
               (i == 0) ? 4 : 0);
    dbg_req = 1'b0;
    #3;
    check("mid_drop_stall", 32'(cpu_stall), 32'd1);
    check("mid_drop_gnt", 32'(dbg_gnt), 32'd0);
    tick(); #3;
    check("after_drop_stall", 32'(cpu_stall), 32'd0);
    check("after_drop_we", 32'(mem_we), 32'd1);
    tick();

    // burst cap: 8 grants, CPU slot, regrant after MAX_WAIT
    for (int i = 0; i < 12; i++)
      dbg_xfer(1'b0, 32'h50 + 32'(4 * (i % 4)), 32'h0,
               words[i % 4], waits[i]);
    dbg_req = 1'b0;
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();

    // async reset in the middle of a granted write beat
    dbg_xfer(1'b1, 32'h64, 32'hA5A5A5A5, 32'h0, 1);
    dbg_req = 1'b1; dbg_we = 1'b1;
    dbg_addr = 32'h68; dbg_wdata = 32'h5A5A5A5A;
    #2;
    check("beat2_gnt", 32'(dbg_gnt), 32'd1);
    check("beat2_we", 32'(mem_we), 32'd1);
    clrn = 1'b0;
    #1;
    check("arst_gnt", 32'(dbg_gnt), 32'd0);
    check("arst_we", 32'(mem_we), 32'd0);
    tick();
    dbg_req = 1'b0; dbg_we = 1'b0; clrn = 1'b1;
    tick();
    cpu_load(32'h64, 32'hA5A5A5A5);
    cpu_load(32'h68, 32'h0);
    tick();

    check("dbg_q_left", 32'(dbg_q.size()), 32'd0);
    check("cpu_q_left", 32'(cpu_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
